// File: rtl/mod_exp_pkg.sv
// Shared types and defaults for the modular exponentiation sequencer.
// Build option MODEXP_SKIP_LEADING_ZEROS_EN is consumed by mod_exp_ctrl.
package mod_exp_pkg;

  localparam int DEF_BITS     = 32;
  localparam int DEF_N_BITS   = 6;
  localparam int DEF_EXP_BITS = 32;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CONV_BASE = 4'd1,
    ST_CONV_ONE  = 4'd2,
    ST_SQUARE    = 4'd3,
    ST_MULT      = 4'd4,
    ST_NEXT_BIT  = 4'd5,
    ST_CONV_OUT  = 4'd6,
    ST_FIX       = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    SEL_ONE  = 3'd0,
    SEL_R2   = 3'd1,
    SEL_ACC  = 3'd2,
    SEL_XB   = 3'd3,
    SEL_BASE = 3'd4
  } opsel_t;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_ISSUE = 2'd1,
    PH_WAIT  = 2'd2
  } mm_phase_t;

endpackage

// File: rtl/mod_exp_ctrl_mm_issue.sv
// ISSUE/WAIT handshake toward the Montgomery multiplier: holds operands,
// pulses mm_start once, captures mm_y on mm_done and flags op_done.
module mod_exp_ctrl_mm_issue
  import mod_exp_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_go,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  input  logic [BITS-1:0] i_mm_y,
  input  logic            i_mm_done,
  output logic            o_mm_start,
  output logic [BITS-1:0] o_mm_a,
  output logic [BITS-1:0] o_mm_b,
  output logic            o_idle,
  output logic            o_op_done,
  output logic [BITS-1:0] o_y
);

  mm_phase_t       r_phase;
  logic            r_op_done;
  logic [BITS-1:0] r_a;
  logic [BITS-1:0] r_b;
  logic [BITS-1:0] r_y;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_phase   <= PH_IDLE;
      r_op_done <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_y       <= '0;
    end else begin
      r_op_done <= 1'b0;
      case (r_phase)
        PH_IDLE: begin
          if (i_go) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_phase <= PH_ISSUE;
          end
        end
        PH_ISSUE: r_phase <= PH_WAIT;
        // mm_done in any other phase is deliberately dropped
        PH_WAIT: begin
          if (i_mm_done) begin
            r_y       <= i_mm_y;
            r_op_done <= 1'b1;
            r_phase   <= PH_IDLE;
          end
        end
        default: r_phase <= PH_IDLE;
      endcase
    end
  end

  assign o_mm_start = (r_phase == PH_ISSUE);
  assign o_mm_a     = r_a;
  assign o_mm_b     = r_b;
  assign o_idle     = (r_phase == PH_IDLE);
  assign o_op_done  = r_op_done;
  assign o_y        = r_y;

endmodule

// File: rtl/mod_exp_ctrl.sv
// Square-and-multiply Montgomery exponentiation sequencer (base^exp mod N).
// Define MODEXP_SKIP_LEADING_ZEROS_EN to start the bit scan at the exponent MSB.
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int N_BITS   = DEF_N_BITS,
  parameter int EXP_BITS = DEF_EXP_BITS
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [BITS-1:0]     i_base,
  input  logic [EXP_BITS-1:0] i_exponent,
  input  logic [BITS-1:0]     i_modulus,
  input  logic [BITS-1:0]     i_r2_mod,
  output logic                o_mm_start,
  output logic [BITS-1:0]     o_mm_a,
  output logic [BITS-1:0]     o_mm_b,
  input  logic [BITS-1:0]     i_mm_y,
  input  logic                i_mm_done,
  output logic [BITS-1:0]     o_result,
  output logic                o_done,
  output logic                o_busy,
  output logic                o_err
);

  localparam int KW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(EXP_BITS - 1);

  // R = 2^N_BITS must be representable and the caller keeps modulus < R
  if (N_BITS < 1 || N_BITS > BITS) begin : g_bad_n_bits
    $error("mod_exp_ctrl: N_BITS must lie in 1..BITS");
  end

  state_t r_state;
  state_t w_next;

  logic [BITS-1:0]     r_base;
  logic [EXP_BITS-1:0] r_exp;
  logic [BITS-1:0]     r_mod;
  logic [BITS-1:0]     r_r2;
  logic [BITS-1:0]     r_xb;
  logic [BITS-1:0]     r_acc;
  logic [BITS-1:0]     r_result;
  logic                r_err;
  logic [KW-1:0]       r_k;

  opsel_t          w_sel_a;
  opsel_t          w_sel_b;
  logic [BITS-1:0] w_a;
  logic [BITS-1:0] w_b;
  logic            w_go;
  logic            w_mm_idle;
  logic            w_op_done;
  logic [BITS-1:0] w_y;
  logic            w_issue_ok;
  logic            w_latch;
  logic            w_cap_xb;
  logic            w_cap_acc;
  logic            w_load_k;
  logic            w_dec_k;
  logic            w_even;
  logic            w_fix;
  logic [KW-1:0]   w_k_init;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  logic [KW-1:0] w_msb;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < EXP_BITS; i++) begin
      if (r_exp[i]) w_msb = KW'(i);
    end
  end
`endif

  function automatic logic [BITS-1:0] sel_operand(input opsel_t sel,
                                                  input logic [BITS-1:0] acc,
                                                  input logic [BITS-1:0] xb,
                                                  input logic [BITS-1:0] r2,
                                                  input logic [BITS-1:0] base);
    case (sel)
      SEL_R2:   return r2;
      SEL_ACC:  return acc;
      SEL_XB:   return xb;
      SEL_BASE: return base;
      default:  return BITS'(1);
    endcase
  endfunction

  // A new op may only be issued once the previous result has been consumed
  assign w_issue_ok = w_mm_idle & ~w_op_done;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_sel_a   = SEL_ONE;
    w_sel_b   = SEL_ONE;
    w_go      = 1'b0;
    w_latch   = 1'b0;
    w_cap_xb  = 1'b0;
    w_cap_acc = 1'b0;
    w_load_k  = 1'b0;
    w_dec_k   = 1'b0;
    w_even    = 1'b0;
    w_fix     = 1'b0;
    w_k_init  = K_TOP;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_latch = 1'b1;
          w_next  = ST_CONV_BASE;
        end
      end
      ST_CONV_BASE: begin
        w_sel_a = SEL_BASE;
        w_sel_b = SEL_R2;
        if (!r_mod[0]) begin
          w_even = 1'b1;
          w_next = ST_DONE;
        end else begin
          w_go = w_issue_ok;
          if (w_op_done) begin
            w_cap_xb = 1'b1;
            w_next   = ST_CONV_ONE;
          end
        end
      end
      ST_CONV_ONE: begin
        w_sel_a = SEL_ONE;
        w_sel_b = SEL_R2;
        w_go    = w_issue_ok;
        if (w_op_done) begin
          w_cap_acc = 1'b1;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
          if (r_exp == '0) begin
            w_next = ST_CONV_OUT;
          end else begin
            w_load_k = 1'b1;
            w_k_init = w_msb;
            w_next   = ST_SQUARE;
          end
`else
          w_load_k = 1'b1;
          w_next   = ST_SQUARE;
`endif
        end
      end
      ST_SQUARE: begin
        w_sel_a = SEL_ACC;
        w_sel_b = SEL_ACC;
        w_go    = w_issue_ok;
        if (w_op_done) begin
          w_cap_acc = 1'b1;
          w_next    = r_exp[r_k] ? ST_MULT : ST_NEXT_BIT;
        end
      end
      ST_MULT: begin
        w_sel_a = SEL_ACC;
        w_sel_b = SEL_XB;
        w_go    = w_issue_ok;
        if (w_op_done) begin
          w_cap_acc = 1'b1;
          w_next    = ST_NEXT_BIT;
        end
      end
      ST_NEXT_BIT: begin
        if (r_k == '0) begin
          w_next = ST_CONV_OUT;
        end else begin
          w_dec_k = 1'b1;
          w_next  = ST_SQUARE;
        end
      end
      ST_CONV_OUT: begin
        w_sel_a = SEL_ACC;
        w_sel_b = SEL_ONE;
        w_go    = w_issue_ok;
        if (w_op_done) begin
          w_cap_acc = 1'b1;
          w_next    = ST_FIX;
        end
      end
      ST_FIX: begin
        w_fix  = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_base   <= '0;
      r_exp    <= '0;
      r_mod    <= '0;
      r_r2     <= '0;
      r_xb     <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_k      <= '0;
    end else begin
      if (w_latch) begin
        r_base <= i_base;
        r_exp  <= i_exponent;
        r_mod  <= i_modulus;
        r_r2   <= i_r2_mod;
        r_err  <= 1'b0;
      end
      if (w_cap_xb)  r_xb  <= w_y;
      if (w_cap_acc) r_acc <= w_y;
      if (w_load_k)     r_k <= w_k_init;
      else if (w_dec_k) r_k <= r_k - KW'(1);
      if (w_even) begin
        r_result <= '0;
        r_err    <= 1'b1;
      end
      // acc stays below 2N through the loop, so one subtraction fully reduces
      if (w_fix) r_result <= (r_acc >= r_mod) ? (r_acc - r_mod) : r_acc;
    end
  end

  assign w_a = sel_operand(w_sel_a, r_acc, r_xb, r_r2, r_base);
  assign w_b = sel_operand(w_sel_b, r_acc, r_xb, r_r2, r_base);

  mod_exp_ctrl_mm_issue #(.BITS(BITS)) u_mm_issue (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_go       (w_go),
    .i_a        (w_a),
    .i_b        (w_b),
    .i_mm_y     (i_mm_y),
    .i_mm_done  (i_mm_done),
    .o_mm_start (o_mm_start),
    .o_mm_a     (o_mm_a),
    .o_mm_b     (o_mm_b),
    .o_idle     (w_mm_idle),
    .o_op_done  (w_op_done),
    .o_y        (w_y)
  );

  assign o_result = r_result;
  assign o_err    = r_err;
  assign o_done   = (r_state == ST_DONE);
  assign o_busy   = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule
